// File: rtl/spi_cmd_sequencer.sv
// SPI master control core: sclk divider, byte/bit counters and command-slot sequencing FSM.
// Define SPI_SEQ_LOOP_EN to repeat the slot 0 read forever instead of parking after slot 3.
module spi_cmd_sequencer #(
  parameter int DIV_HALF  = 10,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power,
  output logic       sclk,
  output logic       cs,
  output logic [1:0] data_select,
  output logic       transfer,
  output logic       receive,
  output logic       byte_start,
  output logic [1:0] byte_count,
  output logic [2:0] bit_count,
  output logic       done
);

  localparam int            CW       = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_HALF - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_TICKS - 1);

  typedef enum logic [2:0] {OFF, SETUP, XFER, HOLD, GAP, PARK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] div_cnt;
  logic          div_wrap, tick;
  logic [1:0]    len, ds_nxt, byte_nxt;
  logic [2:0]    bit_nxt;
  logic [3:0]    gap_cnt, gap_nxt;
  logic          cs_nxt;

  assign div_wrap = (div_cnt == DIV_LAST);
  // tick marks the clk cycle whose closing edge raises sclk
  assign tick     = power && div_wrap && !sclk;

  assign len      = (data_select == 2'd2) ? 2'd2 : 2'd3;
  assign transfer = (state == XFER);
  assign receive  = transfer && (data_select == 2'd0);
  assign done     = (byte_count == len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      sclk        <= 1'b0;
      cs          <= 1'b1;
      state       <= OFF;
      data_select <= 2'd0;
      byte_count  <= 2'd0;
      bit_count   <= 3'd0;
      gap_cnt     <= 4'd0;
    end else if (!power) begin
      div_cnt     <= '0;
      sclk        <= 1'b0;
      cs          <= 1'b1;
      state       <= OFF;
      data_select <= 2'd0;
      byte_count  <= 2'd0;
      bit_count   <= 3'd0;
      gap_cnt     <= 4'd0;
    end else begin
      div_cnt     <= div_wrap ? '0 : div_cnt + CW'(1);
      if (div_wrap) sclk <= ~sclk;
      cs          <= cs_nxt;
      state       <= state_nxt;
      data_select <= ds_nxt;
      byte_count  <= byte_nxt;
      bit_count   <= bit_nxt;
      gap_cnt     <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ds_nxt     = data_select;
    byte_nxt   = byte_count;
    bit_nxt    = bit_count;
    gap_nxt    = gap_cnt;
    byte_start = 1'b0;
    if (tick) begin
      unique case (state)
        OFF: begin
          state_nxt = SETUP;
          ds_nxt    = 2'd1;
        end
        SETUP: begin
          state_nxt  = XFER;
          byte_start = 1'b1;
        end
        XFER: begin
          if (bit_count == 3'd7) begin
            bit_nxt  = 3'd0;
            byte_nxt = byte_count + 2'd1;
            if (byte_count + 2'd1 < len) byte_start = 1'b1;
            else                         state_nxt  = HOLD;
          end else begin
            bit_nxt = bit_count + 3'd1;
          end
        end
        HOLD: begin
          state_nxt = GAP;
          byte_nxt  = 2'd0;
          bit_nxt   = 3'd0;
          gap_nxt   = 4'd0;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state_nxt = SETUP;
            unique case (data_select)
              2'd1:    ds_nxt = 2'd2;
              2'd2:    ds_nxt = 2'd3;
              default: begin
`ifdef SPI_SEQ_LOOP_EN
                ds_nxt    = 2'd0;
`else
                state_nxt = PARK;
`endif
              end
            endcase
          end else begin
            gap_nxt = gap_cnt + 4'd1;
          end
        end
        PARK:    state_nxt = PARK;
        default: state_nxt = OFF;
      endcase
    end
    cs_nxt = !((state_nxt == SETUP) || (state_nxt == XFER) || (state_nxt == HOLD));
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer; define SPI_SEQ_LOOP_EN to exercise the slot 0 repeat mode.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       power;
  logic       sclk, cs, transfer, receive, byte_start, done;
  logic [1:0] data_select, byte_count;
  logic [2:0] bit_count;

  int checks = 0;
  int errors = 0;

  bit saw_bs;
  int m_cs_low, m_xfer, m_rcv, m_bs_n, m_bs_first, m_bs_last;
  int m_done_n, m_done_bc, m_bc5, m_bc13, m_bc21, m_gap_bc, m_gap_bit, m_gap, m_next_ds;

  spi_cmd_sequencer #(.DIV_HALF(10), .GAP_TICKS(2)) dut (
    .clk(clk), .reset(reset), .power(power), .sclk(sclk), .cs(cs),
    .data_select(data_select), .transfer(transfer), .receive(receive),
    .byte_start(byte_start), .byte_count(byte_count), .bit_count(bit_count), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Advance to the negedge sample just after the next sclk rise; note any byte_start on the way.
  task automatic next_tick(output bit ok);
    bit prev;
    ok = 1'b0;
    saw_bs = 1'b0;
    prev = sclk;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (byte_start) saw_bs = 1'b1;
      if (!prev && sclk) begin
        ok = 1'b1;
        break;
      end
      prev = sclk;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL tick_timeout: got no sclk rise expected one within 60 clk");
    end
  endtask

  // Entered at the sample where cs has just fallen; leaves at the next cs fall or deep in PARK.
  task automatic measure_frame;
    bit ok;
    int idx;
    m_cs_low = 1; m_xfer = 0; m_rcv = 0; m_bs_n = 0; m_bs_first = 0; m_bs_last = 0;
    m_done_n = 0; m_done_bc = -1; m_bc5 = -1; m_bc13 = -1; m_bc21 = -1;
    idx = 1;
    for (int i = 0; i < 40; i++) begin
      next_tick(ok);
      if (!ok) break;
      idx++;
      if (saw_bs) begin
        m_bs_n++;
        if (m_bs_n == 1) m_bs_first = idx;
        m_bs_last = idx;
      end
      if (cs) break;
      m_cs_low++;
      if (transfer) m_xfer++;
      if (receive) m_rcv++;
      if (done) begin m_done_n++; m_done_bc = int'(byte_count); end
      if (idx == 5)  m_bc5  = int'(byte_count);
      if (idx == 13) m_bc13 = int'(byte_count);
      if (idx == 21) m_bc21 = int'(byte_count);
    end
    m_gap_bc  = int'(byte_count);
    m_gap_bit = int'(bit_count);
    m_gap = 1;
    for (int j = 0; j < 6; j++) begin
      next_tick(ok);
      if (!ok || !cs) break;
      m_gap++;
    end
    m_next_ds = int'(data_select);
  endtask

  task automatic test_reset;
    reset = 1'b1; power = 1'b0;
    #22;
    @(negedge clk);
    checks++; if (sclk !== 1'b0)         begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (cs !== 1'b1)           begin errors++; $display("FAIL reset_cs: got %b expected 1", cs); end
    checks++; if (data_select !== 2'd0)  begin errors++; $display("FAIL reset_ds: got %0d expected 0", data_select); end
    checks++; if (byte_count !== 2'd0)   begin errors++; $display("FAIL reset_byte: got %0d expected 0", byte_count); end
    checks++; if (bit_count !== 3'd0)    begin errors++; $display("FAIL reset_bit: got %0d expected 0", bit_count); end
    checks++; if ({transfer, receive, byte_start, done} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b expected 0000", {transfer, receive, byte_start, done}); end
  endtask

  task automatic power_on_and_check(input string tag);
    int k;
    power = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k++;
      if (sclk) break;
    end
    checks++; if (k !== 10)             begin errors++; $display("FAIL %s_first_rise: got %0d clk expected 10", tag, k); end
    checks++; if (cs !== 1'b0)          begin errors++; $display("FAIL %s_cs_first_tick: got %b expected 0", tag, cs); end
    checks++; if (data_select !== 2'd1) begin errors++; $display("FAIL %s_ds: got %0d expected 1", tag, data_select); end
    checks++; if (byte_count !== 2'd0)  begin errors++; $display("FAIL %s_byte: got %0d expected 0", tag, byte_count); end
  endtask

  task automatic test_power_up;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (sclk !== 1'b0 || cs !== 1'b1)
      begin errors++; $display("FAIL unpowered_idle: got sclk=%b cs=%b expected 0 1", sclk, cs); end
    power_on_and_check("pwr");
  endtask

  task automatic test_slot1;
    measure_frame();
    checks++; if (m_cs_low !== 26)  begin errors++; $display("FAIL s1_cs_low: got %0d expected 26", m_cs_low); end
    checks++; if (m_xfer !== 24)    begin errors++; $display("FAIL s1_transfer: got %0d expected 24", m_xfer); end
    checks++; if (m_bs_n !== 3)     begin errors++; $display("FAIL s1_bs_count: got %0d expected 3", m_bs_n); end
    checks++; if (m_bs_first !== 2) begin errors++; $display("FAIL s1_bs_first: got %0d expected 2", m_bs_first); end
    checks++; if (m_bs_last !== 18) begin errors++; $display("FAIL s1_bs_last: got %0d expected 18", m_bs_last); end
    checks++; if (m_bc5 !== 0 || m_bc13 !== 1 || m_bc21 !== 2)
      begin errors++; $display("FAIL s1_byte_steps: got %0d,%0d,%0d expected 0,1,2", m_bc5, m_bc13, m_bc21); end
    checks++; if (m_done_n !== 1 || m_done_bc !== 3)
      begin errors++; $display("FAIL s1_done: got n=%0d bc=%0d expected n=1 bc=3", m_done_n, m_done_bc); end
    checks++; if (m_gap_bc !== 0 || m_gap_bit !== 0)
      begin errors++; $display("FAIL s1_gap_clear: got %0d,%0d expected 0,0", m_gap_bc, m_gap_bit); end
    checks++; if (m_gap !== 2)      begin errors++; $display("FAIL s1_gap: got %0d expected 2", m_gap); end
    checks++; if (m_next_ds !== 2)  begin errors++; $display("FAIL s1_next_ds: got %0d expected 2", m_next_ds); end
    checks++; if (m_rcv !== 0)      begin errors++; $display("FAIL s1_receive: got %0d expected 0", m_rcv); end
  endtask

  task automatic test_slot2;
    measure_frame();
    checks++; if (m_cs_low !== 18)  begin errors++; $display("FAIL s2_cs_low: got %0d expected 18", m_cs_low); end
    checks++; if (m_xfer !== 16)    begin errors++; $display("FAIL s2_transfer: got %0d expected 16", m_xfer); end
    checks++; if (m_bs_n !== 2 || m_bs_last !== 10)
      begin errors++; $display("FAIL s2_bs: got n=%0d last=%0d expected n=2 last=10", m_bs_n, m_bs_last); end
    checks++; if (m_done_n !== 1 || m_done_bc !== 2)
      begin errors++; $display("FAIL s2_done: got n=%0d bc=%0d expected n=1 bc=2", m_done_n, m_done_bc); end
    checks++; if (m_gap !== 2)      begin errors++; $display("FAIL s2_gap: got %0d expected 2", m_gap); end
    checks++; if (m_next_ds !== 3)  begin errors++; $display("FAIL s2_next_ds: got %0d expected 3", m_next_ds); end
  endtask

  task automatic test_power_drop;
    bit ok;
    checks++; if (data_select !== 2'd3) begin errors++; $display("FAIL drop_slot: got %0d expected 3", data_select); end
    for (int i = 0; i < 40; i++) begin
      next_tick(ok);
      if (!ok || byte_count == 2'd1) break;
    end
    next_tick(ok);
    checks++; if (cs !== 1'b0 || byte_count !== 2'd1)
      begin errors++; $display("FAIL drop_midframe: got cs=%b bc=%0d expected cs=0 bc=1", cs, byte_count); end
    power = 1'b0;
    @(negedge clk);
    checks++; if (cs !== 1'b1 || sclk !== 1'b0 || transfer !== 1'b0)
      begin errors++; $display("FAIL drop_outputs: got cs=%b sclk=%b xfer=%b expected 1 0 0", cs, sclk, transfer); end
    checks++; if (data_select !== 2'd0 || byte_count !== 2'd0 || bit_count !== 3'd0)
      begin errors++; $display("FAIL drop_counters: got ds=%0d bc=%0d bit=%0d expected 0 0 0", data_select, byte_count, bit_count); end
    repeat (7) @(negedge clk);
    power_on_and_check("repwr");
  endtask

  task automatic test_restart_sequence;
    measure_frame();
    checks++; if (m_cs_low !== 26 || m_next_ds !== 2)
      begin errors++; $display("FAIL rs1: got cs_low=%0d next=%0d expected 26 2", m_cs_low, m_next_ds); end
    measure_frame();
    checks++; if (m_cs_low !== 18 || m_next_ds !== 3)
      begin errors++; $display("FAIL rs2: got cs_low=%0d next=%0d expected 18 3", m_cs_low, m_next_ds); end
  endtask

  task automatic test_slot3_end;
    int lo;
    measure_frame();
    checks++; if (m_cs_low !== 26) begin errors++; $display("FAIL s3_cs_low: got %0d expected 26", m_cs_low); end
    checks++; if (m_rcv !== 0)     begin errors++; $display("FAIL s3_receive: got %0d expected 0", m_rcv); end
`ifdef SPI_SEQ_LOOP_EN
    checks++; if (m_gap !== 2 || m_next_ds !== 0)
      begin errors++; $display("FAIL loop_entry: got gap=%0d ds=%0d expected 2 0", m_gap, m_next_ds); end
    for (int r = 0; r < 3; r++) begin
      measure_frame();
      checks++; if (m_cs_low !== 26 || m_rcv !== 24)
        begin errors++; $display("FAIL loop_rep%0d: got cs_low=%0d rcv=%0d expected 26 24", r, m_cs_low, m_rcv); end
      checks++; if (m_gap !== 2 || m_next_ds !== 0)
        begin errors++; $display("FAIL loop_gap%0d: got gap=%0d ds=%0d expected 2 0", r, m_gap, m_next_ds); end
    end
`else
    checks++; if (m_gap !== 7 || m_next_ds !== 3)
      begin errors++; $display("FAIL park: got cs_high_ticks=%0d ds=%0d expected 7 3", m_gap, m_next_ds); end
    lo = 0;
    repeat (100) begin
      @(negedge clk);
      if (!cs || receive) lo++;
    end
    checks++; if (lo !== 0) begin errors++; $display("FAIL park_hold: got %0d active samples expected 0", lo); end
`endif
  endtask

  task automatic test_duty;
    int hi, lo;
    hi = 0; lo = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!sclk) break; end
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (sclk) break; end
    for (int i = 0; i < 40; i++) begin hi++; @(negedge clk); if (!sclk) break; end
    for (int i = 0; i < 40; i++) begin lo++; @(negedge clk); if (sclk) break; end
    checks++; if (hi !== 10 || lo !== 10)
      begin errors++; $display("FAIL sclk_duty: got high=%0d low=%0d expected 10 10", hi, lo); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (sclk) break; end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (sclk !== 1'b0 || cs !== 1'b1)
      begin errors++; $display("FAIL async_rst_out: got sclk=%b cs=%b expected 0 1", sclk, cs); end
    checks++; if (data_select !== 2'd0 || byte_count !== 2'd0 || bit_count !== 3'd0 || transfer !== 1'b0)
      begin errors++; $display("FAIL async_rst_state: got ds=%0d bc=%0d bit=%0d xfer=%b expected 0 0 0 0",
                               data_select, byte_count, bit_count, transfer); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_slot1();
    test_slot2();
    test_power_drop();
    test_restart_sequence();
    test_slot3_end();
    test_duty();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
